incdec_counter: RTL
===================

# incdec_counter

Registered up/down counter built around the `IncDecC` incrementer-decrementer. The block owns the operand register that feeds `IncDecC.A` and consumes its `Z`/`CO` outputs. A two-stage pipeline accepts commands (increment, decrement, load, hold) over a valid/ready handshake with downstream stall. It then applies each command to the counter register one stage later. It is the stateful wrapper the arithmetic library uses for address generators and loop counters.

## Interface
Parameters:
- `width`, 8: counter word width, ≥ 1.
- `speed`, `lau_pkg::FAST`: forwarded to the internal `IncDecC` instance.
- `saturate`, 0: 0 = wrap on overflow/underflow; 1 = clamp at all-ones/zero.

Ports:
- `CLK`, in, 1: the single clock; all state updates on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `VALID`, in, 1: command valid.
- `READY`, out, 1: command accepted at the edge when `VALID && READY`.
- `OP`, in, 2: 00 INC, 01 DEC, 10 LOAD, 11 HOLD.
- `D`, in, width: load value; used only for LOAD.
- `STALL`, in, 1: downstream backpressure; freezes stage 2.
- `Q`, out, width: counter value (registered).
- `CO`, out, 1: registered carry/borrow of the last applied INC/DEC.
- `ZERO`, out, 1: `Q == 0`, combinational from `Q`.
- `MAX`, out, 1: `Q` all ones, combinational from `Q`.
- `DONE`, out, 1: high for exactly the cycle after a command is applied to `Q`.

## Operation
- **Stage 1 (command register):** holds `s1_valid`, `s1_op`, `s1_d`.
  - Loads on handshake.
  - Clears when its command fires and no new command is accepted.
- **Stage 2 (fire):** occurs when `s1_valid && !STALL`. The `IncDecC` inputs are `A = Q`, `DEC = (s1_op == DEC)`, `CI = (s1_op == INC or DEC)`.
- **INC/DEC, `saturate=0`:** `Q <= Z`, `CO <= IncDecC.CO`. Wrap: 8'hFF + 1 → 8'h00 with CO=1; 8'h00 − 1 → 8'hFF with CO=1.
- **INC/DEC, `saturate=1`:** when `IncDecC.CO=1`, `Q` is unchanged (remains FF on INC, 00 on DEC) and `CO <= 1`. Otherwise the command behaves as in `saturate=0`.
- **LOAD:** `Q <= s1_d`, `CO <= 0`.
- **HOLD:** `Q` unchanged, `CO <= 0`. HOLD still counts as applied (`DONE` pulses).
- **Non-firing cycles:** `Q` and `CO` hold their value; `DONE <= 0`.
- **`READY`:** `= !s1_valid || !STALL`, combinational. It must not depend on `VALID`.
- **Simultaneous fire and accept:** the new command replaces the firing one in stage 1 in the same edge. Throughput is one command per cycle.
- **Back-to-back commands:** each command sees `Q` already updated by its predecessor, so no forwarding is needed.
- **`VALID` while `READY` low:** ignored; the source must hold it. The block does not require `OP`/`D` stability but captures only on handshake.
- **Reset values:** `Q=0`, `CO=0`, `DONE=0`, `s1_valid=0`. Consequently `READY=1`, `ZERO=1`, and `MAX=0` (`MAX=1` only when `width=1` and `Q=1`).
- **Reset mid-operation:** `RST` dominates every other input at that edge. A pending stage-1 command is discarded, with no `DONE` and no `Q` update.

## Timing
- **Acceptance:** at edge k (`VALID && READY`).
- **Earliest application:** edge k+1 when `STALL` is low in cycle k+1's preceding cycle. `Q`, `CO` and `DONE=1` are visible after edge k+1.
- **Latency:** 2 edges from `VALID` presented to `Q` updated, when unstalled.
- **`STALL` held high for n cycles:** delays application by n edges. Stage 1 holds its command, and `READY=0` while `s1_valid` is set.
- **Paths:** `ZERO`, `MAX` and `READY` are combinational outputs. Everything else is a flop output. The critical path is `Q` → `IncDecC` → `Q` mux, governed by `speed`.

## Test plan
- **Reset and single INC** (width=8): assert `RST` for 2 cycles → `Q=00`, `ZERO=1`, `READY=1`, `DONE=0`. Then INC with `VALID` for 1 cycle → 2 edges later `Q=01`, `DONE` high 1 cycle, `CO=0`.
- **Wrap, `saturate=0`:** LOAD FE, then INC, INC, INC back-to-back → `Q` sequence FE, FF, 00, 01. `CO=1` only after the FF→00 step. `MAX=1` while `Q=FF`.
- **Saturate, `saturate=1`:** LOAD 01, then DEC, DEC, DEC → `Q` sequence 01, 00, 00, 00. `CO` is 0, 1, 1. Then INC → `Q=01`, `CO=0`.
- **Stall:** accept DEC with `Q=10`, hold `STALL=1` for 3 cycles → `READY=0`, `Q=10`, `DONE=0` throughout. Release `STALL` → next edge `Q=0F`, `DONE=1`. A second command offered during the stall is accepted only on release.
- **Mid-operation reset:** accept LOAD 55, assert `RST` at the next edge → `Q=00`, no `DONE`, and `s1` empty (`READY=1`).
- **HOLD and fully pipelined stream:** 16 consecutive random INC/DEC/LOAD/HOLD commands with `VALID=1` and no stall → `DONE` high every cycle after the first two. `Q` matches the reference model `DEC ? A−CI : A+CI` (wrapped) at every step.

Source files
------------

// File: rtl/incdec_counter.sv
// Registered up/down counter: a two-stage command pipeline (accept, then fire)
// driving an IncDecC incrementer-decrementer, with optional saturation.

package lau_pkg;
   typedef enum logic [0:0] {
      SLOW = 1'b0,
      FAST = 1'b1
   } speed_t;
endpackage

// Z = DEC ? A - CI : A + CI, with CO the carry (INC) or borrow (DEC) out of the top bit.
module IncDecC #(
   parameter int              width = 8,
   parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
   input  logic [width-1:0] A,
   input  logic             CI,
   input  logic             DEC,
   output logic [width-1:0] Z,
   output logic             CO
);

   if (speed == lau_pkg::FAST) begin : g_fast
      logic [width:0] sum;

      // One wide adder/subtractor; the extra top bit is the carry or borrow.
      always_comb begin
         if (DEC) begin
            sum = {1'b0, A} - {{width{1'b0}}, CI};
         end else begin
            sum = {1'b0, A} + {{width{1'b0}}, CI};
         end
      end

      assign Z  = sum[width-1:0];
      assign CO = sum[width];
   end else begin : g_ripple
      // Half-adder chain: a carry propagates through ones (INC) or a borrow through zeros (DEC).
      always_comb begin : ripple
         logic c;
         c  = CI;
         Z  = {width{1'b0}};
         for (int i = 0; i < width; i++) begin
            Z[i] = A[i] ^ c;
            if (DEC) begin
               c = ~A[i] & c;
            end else begin
               c = A[i] & c;
            end
         end
         CO = c;
      end
   end

endmodule

module incdec_counter #(
   parameter int              width    = 8,
   parameter lau_pkg::speed_t speed    = lau_pkg::FAST,
   parameter int              saturate = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             VALID,
   output logic             READY,
   input  logic [1:0]       OP,
   input  logic [width-1:0] D,
   input  logic             STALL,
   output logic [width-1:0] Q,
   output logic             CO,
   output logic             ZERO,
   output logic             MAX,
   output logic             DONE
);

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_LOAD = 2'b10,
      OP_HOLD = 2'b11
   } op_t;

   localparam bit sat_en = (saturate != 0);

   logic             s1_valid;
   op_t              s1_op;
   logic [width-1:0] s1_d;

   logic             accept;
   logic             fire;
   logic             id_dec;
   logic             id_ci;
   logic [width-1:0] id_z;
   logic             id_co;
   logic [width-1:0] q_next;
   logic             co_next;

   assign READY  = !s1_valid || !STALL;
   assign accept = VALID && READY;
   assign fire   = s1_valid && !STALL;

   // Stage 1: a new command replaces a firing one on the same edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_HOLD;
         s1_d     <= {width{1'b0}};
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= op_t'(OP);
         s1_d     <= D;
      end else if (fire) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= s1_valid;
      end
   end

   assign id_dec = (s1_op == OP_DEC);
   assign id_ci  = (s1_op == OP_INC) || (s1_op == OP_DEC);

   IncDecC #(
      .width(width),
      .speed(speed)
   ) u_incdec (
      .A  (Q),
      .CI (id_ci),
      .DEC(id_dec),
      .Z  (id_z),
      .CO (id_co)
   );

   // Result selection for the command sitting in stage 1.
   always_comb begin
      q_next  = Q;
      co_next = CO;
      case (s1_op)
         OP_INC, OP_DEC: begin
            if (sat_en && id_co) begin
               q_next  = Q;
               co_next = 1'b1;
            end else begin
               q_next  = id_z;
               co_next = id_co;
            end
         end
         OP_LOAD: begin
            q_next  = s1_d;
            co_next = 1'b0;
         end
         OP_HOLD: begin
            q_next  = Q;
            co_next = 1'b0;
         end
         default: begin
            q_next  = Q;
            co_next = 1'b0;
         end
      endcase
   end

   // Stage 2: Q/CO only move on a firing edge; DONE marks that edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Q    <= {width{1'b0}};
         CO   <= 1'b0;
         DONE <= 1'b0;
      end else if (fire) begin
         Q    <= q_next;
         CO   <= co_next;
         DONE <= 1'b1;
      end else begin
         Q    <= Q;
         CO   <= CO;
         DONE <= 1'b0;
      end
   end

   assign ZERO = (Q == {width{1'b0}});
   assign MAX  = &Q;

endmodule
